// File: rtl/id_ex_elastic_reg.sv
// rtl/id_ex_elastic_reg.sv - ID/EX pipeline register with 2-entry skid buffer, flush and stall counter
module id_ex_elastic_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FUNC_W = 6,
    parameter int WB_W   = 2,
    parameter int MEM_W  = 3,
    parameter int EX_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rt_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic [DATA_W-1:0] rd1_id,
    input  logic [DATA_W-1:0] rd2_id,
    input  logic [DATA_W-1:0] imm_id,
    input  logic [WB_W-1:0]   wb_id,
    input  logic [MEM_W-1:0]  mem_id,
    input  logic [EX_W-1:0]   ex_id,
    input  logic [FUNC_W-1:0] func_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] rt_ex,
    output logic [REG_AW-1:0] rd_ex,
    output logic [DATA_W-1:0] rd1_ex,
    output logic [DATA_W-1:0] rd2_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [WB_W-1:0]   wb_ex,
    output logic [MEM_W-1:0]  mem_ex,
    output logic [EX_W-1:0]   ex_ex,
    output logic [FUNC_W-1:0] func_ex,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = 2*REG_AW + 3*DATA_W + WB_W + MEM_W + EX_W + FUNC_W;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    logic [PW-1:0]     main_q;
    logic [PW-1:0]     skid_q;
    logic [PW-1:0]     in_pl;
    logic              in_fire;
    logic              out_fire;
    logic [WB_W-1:0]   main_wb;
    logic [MEM_W-1:0]  main_mem;
    logic [EX_W-1:0]   main_ex;

    assign in_pl = {rt_id, rd_id, rd1_id, rd2_id, imm_id, wb_id, mem_id, ex_id, func_id};

    // Both handshake outputs decode registered state only, so ready never depends on out_ready.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_pl;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_pl;
                    end else if (in_fire) begin
                        skid_q <= in_pl;
                        state  <= FULL;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign {rt_ex, rd_ex, rd1_ex, rd2_ex, imm_ex, main_wb, main_mem, main_ex, func_ex} = main_q;

    // A bubble must never carry live control into EX, so control fields are gated by valid.
    assign wb_ex  = out_valid ? main_wb  : '0;
    assign mem_ex = out_valid ? main_mem : '0;
    assign ex_ex  = out_valid ? main_ex  : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
